// File: rtl/mfm_pkg.sv
// rtl/mfm_pkg.sv - shared types and constants for the MFM read sequencer
package mfm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACQUIRE,
    ST_SYNC,
    ST_DATA,
    ST_DONE
  } state_e;

  localparam logic [15:0] SYNC_A1_MFM  = 16'h4489;
  localparam logic [7:0]  SYNC_A1_BYTE = 8'hA1;
  localparam logic [15:0] CRC16_POLY   = 16'h1021;
  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;

  // Data half-cells sit in the even positions of a clock/data pair window.
  function automatic logic [7:0] mfm_data_bits(input logic [15:0] sh);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = sh[2*i];
    return r;
  endfunction

endpackage

// File: rtl/mfm_crc16.sv
// rtl/mfm_crc16.sv - bytewise CRC-16/CCITT update, MSB first
module mfm_crc16
  import mfm_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data_in[i]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
      else                    c = {c[14:0], 1'b0};
    end
    crc_out = c;
  end

endmodule

// File: rtl/mfm_read_sequencer.sv
// rtl/mfm_read_sequencer.sv - DPLL lock, A1 sync hunt and byte deserialiser for MFM reads
// Optional CRC-16 residue check is built when MFM_CRC_EN is defined.
module mfm_read_sequencer
  import mfm_pkg::*;
#(
  parameter int PREAMBLE_CELLS = 64,
  parameter int SYNC_COUNT     = 3,
  parameter int TIMEOUT_CELLS  = 4096,
  parameter int LEN_W          = 10
) (
  input  logic             clk_50,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] byte_count,
  input  logic             cell_strobe,
  input  logic             cell_bit,
  output logic             pll_reset,
  output logic             busy,
  output logic             byte_valid,
  output logic [7:0]       byte_data,
  output logic             done,
  output logic             err_timeout,
  output logic             err_mfm,
  output logic             crc_ok
);

  localparam int RUN_W  = $clog2(PREAMBLE_CELLS + 1);
  localparam int SYNC_W = $clog2(SYNC_COUNT + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CELLS + 1);
  localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(PREAMBLE_CELLS);
  localparam logic [SYNC_W-1:0] SYNC_MAX = SYNC_W'(SYNC_COUNT);
  localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(TIMEOUT_CELLS);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d, byte_cnt_q, byte_cnt_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [SYNC_W-1:0] sync_cnt_q, sync_cnt_d;
  logic [3:0]        cell_cnt_q, cell_cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [15:0]       shreg_q, shreg_d, shreg_shift;
  logic              prev_bit_q, prev_bit_d, last_q, last_d;
  logic              byte_valid_q, byte_valid_d;
  logic [7:0]        byte_data_q, byte_data_d;
  logic              err_timeout_q, err_timeout_d, err_mfm_q, err_mfm_d;
  logic              tmo_hit, preamble_ok, sync_miss, sync_done;

  always_comb begin
    len_d         = len_q;
    byte_cnt_d    = byte_cnt_q;
    run_d         = run_q;
    sync_cnt_d    = sync_cnt_q;
    cell_cnt_d    = cell_cnt_q;
    tmo_d         = tmo_q;
    shreg_d       = shreg_q;
    prev_bit_d    = prev_bit_q;
    last_d        = last_q;
    byte_valid_d  = 1'b0;
    byte_data_d   = byte_data_q;
    err_timeout_d = err_timeout_q;
    err_mfm_d     = err_mfm_q;
    tmo_hit       = 1'b0;
    preamble_ok   = 1'b0;
    sync_miss     = 1'b0;
    sync_done     = 1'b0;
    shreg_shift   = {shreg_q[14:0], cell_bit};
    case (state_q)
      ST_IDLE: if (start) begin
        len_d         = byte_count;
        byte_cnt_d    = '0;
        run_d         = '0;
        sync_cnt_d    = '0;
        cell_cnt_d    = '0;
        tmo_d         = '0;
        shreg_d       = '0;
        prev_bit_d    = 1'b0;
        last_d        = 1'b0;
        err_timeout_d = 1'b0;
        err_mfm_d     = 1'b0;
      end
      ST_ACQUIRE, ST_SYNC: if (cell_strobe) begin
        shreg_d    = shreg_shift;
        prev_bit_d = cell_bit;
        if (tmo_q != TMO_MAX) tmo_d = tmo_q + TMO_W'(1);
        tmo_hit       = (tmo_d == TMO_MAX);
        err_timeout_d = err_timeout_q | tmo_hit;
        if (state_q == ST_ACQUIRE) begin
          if (cell_bit != prev_bit_q) begin
            if (run_q != RUN_MAX) run_d = run_q + RUN_W'(1);
          end else begin
            run_d = '0;
          end
          preamble_ok = (run_d == RUN_MAX);
        end else if (sync_cnt_q == '0) begin
          // Free-running hunt until the first mark fixes the 16-cell framing.
          if (shreg_shift == SYNC_A1_MFM) begin
            sync_cnt_d = SYNC_W'(1);
            cell_cnt_d = '0;
          end
        end else begin
          cell_cnt_d = cell_cnt_q + 4'd1;
          if (cell_cnt_q == 4'd15) begin
            if (shreg_shift == SYNC_A1_MFM) begin
              sync_cnt_d = sync_cnt_q + SYNC_W'(1);
            end else begin
              sync_miss  = 1'b1;
              sync_cnt_d = '0;
              run_d      = '0;
            end
          end
        end
        sync_done = (state_q == ST_SYNC) && (sync_cnt_d == SYNC_MAX);
      end
      ST_DATA: if (cell_strobe && !last_q) begin
        shreg_d    = shreg_shift;
        cell_cnt_d = cell_cnt_q + 4'd1;
        if (shreg_shift[1:0] == 2'b11 || shreg_shift[3:0] == 4'h0) err_mfm_d = 1'b1;
        if (cell_cnt_q == 4'd15) begin
          byte_valid_d = 1'b1;
          byte_data_d  = mfm_data_bits(shreg_shift);
          byte_cnt_d   = byte_cnt_q + LEN_W'(1);
          last_d       = (byte_cnt_d == len_q);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_ACQUIRE;
      ST_ACQUIRE: if (tmo_hit) state_d = ST_DONE;
                  else if (preamble_ok) state_d = ST_SYNC;
      ST_SYNC:    if (tmo_hit) state_d = ST_DONE;
                  else if (sync_miss) state_d = ST_ACQUIRE;
                  else if (sync_done) state_d = (len_q == '0) ? ST_DONE : ST_DATA;
      // One extra DATA cycle puts done one cycle after the final byte_valid.
      ST_DATA:    if (last_q) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      len_q         <= '0;
      byte_cnt_q    <= '0;
      run_q         <= '0;
      sync_cnt_q    <= '0;
      cell_cnt_q    <= '0;
      tmo_q         <= '0;
      shreg_q       <= '0;
      prev_bit_q    <= 1'b0;
      last_q        <= 1'b0;
      byte_valid_q  <= 1'b0;
      byte_data_q   <= 8'h00;
      err_timeout_q <= 1'b0;
      err_mfm_q     <= 1'b0;
    end else begin
      len_q         <= len_d;
      byte_cnt_q    <= byte_cnt_d;
      run_q         <= run_d;
      sync_cnt_q    <= sync_cnt_d;
      cell_cnt_q    <= cell_cnt_d;
      tmo_q         <= tmo_d;
      shreg_q       <= shreg_d;
      prev_bit_q    <= prev_bit_d;
      last_q        <= last_d;
      byte_valid_q  <= byte_valid_d;
      byte_data_q   <= byte_data_d;
      err_timeout_q <= err_timeout_d;
      err_mfm_q     <= err_mfm_d;
    end
  end

  always_comb begin
    pll_reset   = (state_q == ST_IDLE);
    busy        = (state_q == ST_ACQUIRE) || (state_q == ST_SYNC) || (state_q == ST_DATA);
    done        = (state_q == ST_DONE);
    byte_valid  = byte_valid_q;
    byte_data   = byte_data_q;
    err_timeout = err_timeout_q;
    err_mfm     = err_mfm_q;
  end

`ifdef MFM_CRC_EN
  logic [15:0] crc_q, crc_d, crc_next;

  mfm_crc16 u_crc16 (
    .crc_in  (crc_q),
    .data_in (byte_valid_d ? byte_data_d : SYNC_A1_BYTE),
    .crc_out (crc_next)
  );

  // Each accepted A1 mark folds an A1 byte in; a broken sync run restarts the CRC.
  always_comb begin
    crc_d = crc_q;
    if (state_q == ST_IDLE && start) crc_d = CRC16_INIT;
    else if (state_q == ST_SYNC && sync_miss) crc_d = CRC16_INIT;
    else if ((state_q == ST_SYNC && sync_cnt_d > sync_cnt_q) || byte_valid_d) crc_d = crc_next;
  end

  always_ff @(posedge clk_50) begin
    if (!rst_n) crc_q <= CRC16_INIT;
    else        crc_q <= crc_d;
  end

  assign crc_ok = (state_q == ST_DONE) && (crc_q == 16'h0000) && !err_timeout_q;
`else
  assign crc_ok = 1'b0;
`endif

endmodule

// File: tb/tb_mfm_read_sequencer.sv
// tb/tb_mfm_read_sequencer.sv - directed self-checking bench for mfm_read_sequencer
module tb_mfm_read_sequencer;

  logic       clk_50 = 1'b0;
  logic       rst_n, start, cell_strobe, cell_bit;
  logic [9:0] byte_count;
  logic       pll_reset, busy, byte_valid, done, err_timeout, err_mfm, crc_ok;
  logic [7:0] byte_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int bv_cyc = 0;
  int done_cyc = 0;
  logic mfm_at_done, crc_at_done;
  logic [7:0] got[$];
  logic tb_prev;

  always #5 clk_50 = ~clk_50;
  always @(posedge clk_50) cyc <= cyc + 1;

  mfm_read_sequencer dut (
    .clk_50(clk_50), .rst_n(rst_n), .start(start), .byte_count(byte_count),
    .cell_strobe(cell_strobe), .cell_bit(cell_bit), .pll_reset(pll_reset),
    .busy(busy), .byte_valid(byte_valid), .byte_data(byte_data), .done(done),
    .err_timeout(err_timeout), .err_mfm(err_mfm), .crc_ok(crc_ok)
  );

  always @(negedge clk_50) begin
    if (byte_valid) begin
      got.push_back(byte_data);
      bv_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      mfm_at_done = err_mfm;
      crc_at_done = crc_ok;
    end
  end

  function automatic logic [15:0] mfm_enc(input logic [7:0] d, input logic prev);
    logic [15:0] r;
    logic p;
    p = prev;
    for (int i = 7; i >= 0; i--) begin
      r[2*i+1] = ~(p | d[i]);
      r[2*i]   = d[i];
      p        = d[i];
    end
    return r;
  endfunction

  task automatic send_cell(input logic b);
    @(negedge clk_50);
    cell_strobe = 1'b1;
    cell_bit    = b;
    @(negedge clk_50);
    cell_strobe = 1'b0;
    cell_bit    = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_cell(w[i]);
  endtask

  task automatic send_preamble();
    for (int i = 0; i < 64; i++) send_cell(i % 2 == 0);
  endtask

  task automatic send_syncs();
    for (int i = 0; i < 3; i++) send_word(16'h4489);
    tb_prev = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_word(mfm_enc(d, tb_prev));
    tb_prev = d[0];
  endtask

  task automatic pulse_start(input logic [9:0] len);
    @(negedge clk_50);
    start      = 1'b1;
    byte_count = len;
    @(negedge clk_50);
    start = 1'b0;
    n_cmp++;
    if ({busy, pll_reset} !== 2'b10) begin
      n_bad++;
      $display("FAIL start_accept: busy,pll_reset=%b required 10", {busy, pll_reset});
    end
  endtask

  task automatic wait_done(input logic poke_start);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk_50);
      if (done) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL wait_done: done not seen within 200 cycles, required 1");
    end
    if (poke_start) start = 1'b1;
    @(negedge clk_50);
    start = 1'b0;
    n_cmp++;
    if ({busy, pll_reset} !== 2'b01) begin
      n_bad++;
      $display("FAIL after_done: busy,pll_reset=%b required 01", {busy, pll_reset});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; cell_strobe = 1'b0; cell_bit = 1'b0; byte_count = '0;
    repeat (3) @(negedge clk_50);
    n_cmp++;
    if ({pll_reset, busy, byte_valid, done, err_timeout, err_mfm, crc_ok, byte_data} !== 15'h4000) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h required 4000",
               {pll_reset, busy, byte_valid, done, err_timeout, err_mfm, crc_ok, byte_data});
    end
    rst_n = 1'b1;
    @(negedge clk_50);
  endtask

  task automatic test_idle_strobes();
    int d0;
    got.delete();
    d0 = done_cnt;
    for (int i = 0; i < 20; i++) send_cell(i % 2 == 0);
    n_cmp++;
    if (got.size() != 0 || done_cnt != d0 || busy !== 1'b0 || pll_reset !== 1'b1) begin
      n_bad++;
      $display("FAIL idle_strobes: bytes=%0d dones=%0d busy=%b pll_reset=%b required 0 0 0 1",
               got.size(), done_cnt - d0, busy, pll_reset);
    end
  endtask

  task automatic test_basic_read();
    int d0;
    got.delete();
    d0 = done_cnt;
    pulse_start(10'd2);
    send_preamble();
    send_syncs();
    send_byte(8'h5A);
    send_byte(8'hC3);
    wait_done(1'b1);
    repeat (3) @(negedge clk_50);
    n_cmp++;
    if (got.size() != 2) begin
      n_bad++;
      $display("FAIL basic_count: got %0d bytes required 2", got.size());
    end else begin
      n_cmp++;
      if (got[0] !== 8'h5A) begin n_bad++; $display("FAIL basic_byte0: got %h required 5a", got[0]); end
      n_cmp++;
      if (got[1] !== 8'hC3) begin n_bad++; $display("FAIL basic_byte1: got %h required c3", got[1]); end
    end
    n_cmp++;
    if (done_cnt != d0 + 1) begin n_bad++; $display("FAIL basic_done_count: got %0d required 1", done_cnt - d0); end
    n_cmp++;
    if (done_cyc != bv_cyc + 1) begin n_bad++; $display("FAIL basic_done_timing: done-byte_valid=%0d required 1", done_cyc - bv_cyc); end
    n_cmp++;
    if (mfm_at_done !== 1'b0) begin n_bad++; $display("FAIL basic_err_mfm: got %b required 0", mfm_at_done); end
    n_cmp++;
    if (crc_at_done !== 1'b0) begin n_bad++; $display("FAIL basic_crc_ok: got %b required 0", crc_at_done); end
  endtask

  task automatic test_sync_mismatch();
    got.delete();
    pulse_start(10'd1);
    send_preamble();
    send_word(16'h4489);
    send_word(16'hAAAA);
    n_cmp++;
    if (busy !== 1'b1 || got.size() != 0) begin
      n_bad++;
      $display("FAIL mismatch_busy: busy=%b bytes=%0d required 1 0", busy, got.size());
    end
    send_preamble();
    send_syncs();
    send_byte(8'h3C);
    wait_done(1'b0);
    n_cmp++;
    if (got.size() != 1 || got[0] !== 8'h3C) begin
      n_bad++;
      $display("FAIL mismatch_byte: bytes=%0d first=%h required 1 3c", got.size(), got.size() ? got[0] : 8'h00);
    end
    n_cmp++;
    if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL mismatch_timeout: got %b required 0", err_timeout); end
  endtask

  task automatic test_timeout();
    got.delete();
    pulse_start(10'd1);
    for (int i = 0; i < 4095; i++) send_cell(1'b0);
    n_cmp++;
    if ({done, busy, err_timeout} !== 3'b010) begin
      n_bad++;
      $display("FAIL timeout_4095: done,busy,err_timeout=%b required 010", {done, busy, err_timeout});
    end
    send_cell(1'b0);
    n_cmp++;
    if ({done, busy, err_timeout} !== 3'b101) begin
      n_bad++;
      $display("FAIL timeout_4096: done,busy,err_timeout=%b required 101", {done, busy, err_timeout});
    end
    repeat (4) @(negedge clk_50);
    n_cmp++;
    if ({err_timeout, pll_reset, got.size() == 0} !== 3'b111) begin
      n_bad++;
      $display("FAIL timeout_sticky: err_timeout,pll_reset,no_bytes=%b required 111",
               {err_timeout, pll_reset, got.size() == 0});
    end
  endtask

  task automatic test_mfm_error();
    got.delete();
    pulse_start(10'd2);
    n_cmp++;
    if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL err_clear_on_start: got %b required 0", err_timeout); end
    send_preamble();
    send_syncs();
    send_word(mfm_enc(8'h5A, tb_prev) ^ 16'h8000);
    tb_prev = 1'b0;
    n_cmp++;
    if (err_mfm !== 1'b1) begin n_bad++; $display("FAIL mfm_flag: got %b required 1", err_mfm); end
    send_byte(8'hC3);
    wait_done(1'b0);
    n_cmp++;
    if (got.size() != 2 || got[0] !== 8'h5A || got[1] !== 8'hC3) begin
      n_bad++;
      $display("FAIL mfm_bytes: count=%0d required 2 bytes 5a c3", got.size());
    end
    n_cmp++;
    if (mfm_at_done !== 1'b1 || err_mfm !== 1'b1) begin
      n_bad++;
      $display("FAIL mfm_sticky: at_done=%b now=%b required 1 1", mfm_at_done, err_mfm);
    end
  endtask

  task automatic test_reset_mid_data();
    int d0;
    logic [15:0] w;
    got.delete();
    pulse_start(10'd3);
    send_preamble();
    send_syncs();
    send_word(mfm_enc(8'h5A, tb_prev) ^ 16'h8000);
    w = mfm_enc(8'hC3, 1'b0);
    for (int i = 15; i >= 8; i--) send_cell(w[i]);
    n_cmp++;
    if (err_mfm !== 1'b1 || got.size() != 1) begin
      n_bad++;
      $display("FAIL middata_setup: err_mfm=%b bytes=%0d required 1 1", err_mfm, got.size());
    end
    d0 = done_cnt;
    @(negedge clk_50);
    rst_n = 1'b0;
    repeat (3) @(negedge clk_50);
    n_cmp++;
    if ({pll_reset, busy, byte_valid, done, err_timeout, err_mfm, crc_ok, byte_data} !== 15'h4000) begin
      n_bad++;
      $display("FAIL middata_reset: got %h required 4000",
               {pll_reset, busy, byte_valid, done, err_timeout, err_mfm, crc_ok, byte_data});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) send_cell(w[i]);
    repeat (20) @(negedge clk_50);
    n_cmp++;
    if (done_cnt != d0 || got.size() != 1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL middata_no_done: dones=%0d bytes=%0d busy=%b required 0 1 0", done_cnt - d0, got.size(), busy);
    end
  endtask

`ifdef MFM_CRC_EN
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  task automatic test_crc(input logic corrupt);
    logic [7:0]  pl [0:10];
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < 3; i++) c = crc_upd(c, 8'hA1);
    for (int i = 0; i < 9; i++) begin
      pl[i] = 8'h31 + 8'(i);
      c = crc_upd(c, pl[i]);
    end
    pl[9]  = c[15:8];
    pl[10] = c[7:0];
    if (corrupt) pl[4] = pl[4] ^ 8'h01;
    got.delete();
    pulse_start(10'd11);
    send_preamble();
    send_syncs();
    for (int i = 0; i < 11; i++) send_byte(pl[i]);
    wait_done(1'b0);
    n_cmp++;
    if (got.size() != 11 || crc_at_done !== !corrupt) begin
      n_bad++;
      $display("FAIL crc_result: bytes=%0d crc_ok=%b required 11 %b", got.size(), crc_at_done, !corrupt);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

  initial begin
    tb_prev = 1'b0;
    test_reset();
    test_idle_strobes();
    test_basic_read();
    test_sync_mismatch();
    test_timeout();
    test_mfm_error();
    test_reset_mid_data();
`ifdef MFM_CRC_EN
    test_crc(1'b0);
    test_crc(1'b1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
